npu_cmd_sched: RTL and testbench
================================

Name: npu_cmd_sched

Overview:
In-order command scheduler between the ALU stage and the three accelerator engines: DMA for ld/st, MM for conv, and VEC for act/pool. It buffers decoded custom commands in a small FIFO. It dispatches the head command to its engine once that engine is idle and no SRAM (iram/wram/oram) hazard exists against in-flight work. WFI is retired only when every engine has drained.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
PLD_W, 64, opaque command payload width, forwarded unchanged to engines

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
alu_sch_vld  in  1  command valid
alu_sch_cmd  in  4  0 LD_IRAM,1 LD_WRAM,2 ST_IRAM,3 ST_WRAM,4 ST_ORAM,5 CONV,6 ACT,7 POOL,8 WFI; 9-15 illegal
alu_sch_pld  in  PLD_W  command payload
sch_alu_rdy  out  1  FIFO can accept
alu_sch_flush  in  1  discard all queued (undispatched) commands
sch_dma_vld / sch_mm_vld / sch_vec_vld  out  1 each  dispatch request per engine
dma_sch_rdy / mm_sch_rdy / vec_sch_rdy  in  1 each  engine accepts
dma_sch_done / mm_sch_done / vec_sch_done  in  1 each  one-cycle completion pulse
sch_cmd  out  4  head command code (shared bus)
sch_pld  out  PLD_W  head payload (shared bus)
sch_wfi_done  out  1  one-cycle pulse: WFI retired
sch_err  out  1  one-cycle pulse: illegal code dropped
sch_busy  out  1  FIFO non-empty or any engine in flight

Behaviour:
- Reset (rst_n=0 at clk edge): FIFO empty, all engines IDLE, all in-flight masks 0. Outputs after reset: sch_alu_rdy=1, all *_vld=0, sch_wfi_done=0, sch_err=0, sch_busy=0. sch_cmd and sch_pld are 0.
- Push: alu_sch_vld & sch_alu_rdy & ~alu_sch_flush. sch_alu_rdy = ~full from registered count; there is no same-cycle push when full, even if a pop occurs.
- Illegal code: never enqueued. sch_err pulses the following cycle. sch_alu_rdy is unaffected.
- Resource sets, as (read R, write W):
  - LD_IRAM: R none, W iram. LD_WRAM: R none, W wram.
  - ST_x: R x, W none.
  - CONV: R iram+wram, W oram.
  - ACT/POOL: R oram, W oram.
- Hazard: head.W & (infl_R|infl_W) != 0, or head.R & infl_W != 0. infl_* is the OR of the registered masks of BUSY engines.
- Engine mapping: LD/ST to DMA, CONV to MM, ACT/POOL to VEC. Each engine has a 2-state FSM:
  - IDLE -> BUSY on dispatch handshake (vld&rdy); this loads the engine mask with the head's R/W.
  - BUSY -> IDLE on *_done; this clears the mask at the same edge.
  - A done while IDLE is ignored.
- Dispatch: sch_X_vld = FIFO non-empty & head maps to X & X IDLE & no hazard. The decision uses registered state only. A done affects hazards from the next cycle, giving 1-cycle done-to-dispatch latency.
- Once asserted, vld stays high with stable cmd/pld until rdy. State changes while waiting only remove conflicts, so this holds by construction. Pop occurs on the handshake.
- Strict in-order: only the head is considered. A blocked head stalls all younger commands.
- WFI at head: pops when all three engines are IDLE, with no engine vld. sch_wfi_done pulses that same cycle.
- sch_cmd/sch_pld always show the head entry, and 0 when empty.
- Flush: the FIFO is emptied at the edge. A dispatch handshake in the flush cycle still completes, and that engine goes BUSY. The push in that cycle is dropped. In-flight engines are unaffected.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits. A simultaneous push and pop keeps the count unchanged.
- sch_busy is combinational from registered count and engine states.

Test Plan:
- Reset, then push LD_IRAM, then CONV with dma_rdy=1 and mm_rdy=1:
  - LD dispatches the cycle after the push.
  - CONV is held (iram RAW) until dma_done, then sch_mm_vld rises 1 cycle after done.
- Push CONV, then ST_WRAM, with mm busy:
  - ST_WRAM dispatches to DMA while CONV is in flight (R/R on wram is not a hazard).
  - A following LD_WRAM is then blocked until mm_done (WAR on wram).
- Fill 4 commands with all rdy=0 -> sch_alu_rdy=0 and a 5th push is ignored. Raising dma_rdy pops one entry and rdy returns to 1 the next cycle.
- ACT in flight, WFI queued -> sch_wfi_done stays low until vec_done. It pulses exactly 1 cycle later, and sch_busy falls.
- Push cmd=12 -> sch_err pulses once, the FIFO stays empty, and sch_busy=0.
- 3 queued commands, head handshake coincident with alu_sch_flush -> the head engine goes BUSY, the other 2 entries are discarded, and sch_busy stays 1 until that engine's done.

Source files
------------

// File: rtl/npu_cmd_sched.sv
// In-order command scheduler: queues decoded commands and issues the head to DMA/MM/VEC
// once its engine is idle and no SRAM hazard exists against in-flight engine masks.
module npu_cmd_sched #(
  parameter int DEPTH = 4,
  parameter int PLD_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_sch_vld,
  input  logic [3:0]       alu_sch_cmd,
  input  logic [PLD_W-1:0] alu_sch_pld,
  output logic             sch_alu_rdy,
  input  logic             alu_sch_flush,
  output logic             sch_dma_vld,
  output logic             sch_mm_vld,
  output logic             sch_vec_vld,
  input  logic             dma_sch_rdy,
  input  logic             mm_sch_rdy,
  input  logic             vec_sch_rdy,
  input  logic             dma_sch_done,
  input  logic             mm_sch_done,
  input  logic             vec_sch_done,
  output logic [3:0]       sch_cmd,
  output logic [PLD_W-1:0] sch_pld,
  output logic             sch_wfi_done,
  output logic             sch_err,
  output logic             sch_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  localparam logic [3:0] C_LD_IRAM = 4'd0;
  localparam logic [3:0] C_LD_WRAM = 4'd1;
  localparam logic [3:0] C_ST_IRAM = 4'd2;
  localparam logic [3:0] C_ST_WRAM = 4'd3;
  localparam logic [3:0] C_ST_ORAM = 4'd4;
  localparam logic [3:0] C_CONV    = 4'd5;
  localparam logic [3:0] C_ACT     = 4'd6;
  localparam logic [3:0] C_POOL    = 4'd7;
  localparam logic [3:0] C_WFI     = 4'd8;

  // Resource bits: [0] iram, [1] wram, [2] oram.
  localparam logic [2:0] R_IRAM = 3'b001;
  localparam logic [2:0] R_WRAM = 3'b010;
  localparam logic [2:0] R_ORAM = 3'b100;

  // Engine indices: 0 DMA, 1 MM, 2 VEC; 3 means no engine (WFI).
  typedef enum logic {ENG_IDLE, ENG_BUSY} eng_state_t;

  logic [3:0]       cmd_q [DEPTH];
  logic [PLD_W-1:0] pld_q [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             empty, full;
  logic             push, pop, wfi_pop, illegal;
  logic             err_q;

  logic [3:0]       head_cmd;
  logic [PLD_W-1:0] head_pld;
  logic [2:0]       head_r, head_w;
  logic [1:0]       head_eng;

  eng_state_t       eng_st  [3];
  eng_state_t       eng_nxt [3];
  logic [2:0]       eng_r   [3];
  logic [2:0]       eng_w   [3];
  logic [2:0]       eng_vld, eng_rdy, eng_done, eng_hs;
  logic [2:0]       infl_r, infl_w;
  logic             hazard, all_idle;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign head_cmd = empty ? 4'd0 : cmd_q[rd_ptr];
  assign head_pld = empty ? '0 : pld_q[rd_ptr];
  assign illegal  = (alu_sch_cmd > C_WFI);
  assign push     = alu_sch_vld & ~full & ~alu_sch_flush & ~illegal;

  assign eng_rdy  = {vec_sch_rdy, mm_sch_rdy, dma_sch_rdy};
  assign eng_done = {vec_sch_done, mm_sch_done, dma_sch_done};

  always_comb begin
    head_r   = '0;
    head_w   = '0;
    head_eng = 2'd3;
    case (head_cmd)
      C_LD_IRAM: begin head_w = R_IRAM; head_eng = 2'd0; end
      C_LD_WRAM: begin head_w = R_WRAM; head_eng = 2'd0; end
      C_ST_IRAM: begin head_r = R_IRAM; head_eng = 2'd0; end
      C_ST_WRAM: begin head_r = R_WRAM; head_eng = 2'd0; end
      C_ST_ORAM: begin head_r = R_ORAM; head_eng = 2'd0; end
      C_CONV:    begin head_r = R_IRAM | R_WRAM; head_w = R_ORAM; head_eng = 2'd1; end
      C_ACT,
      C_POOL:    begin head_r = R_ORAM; head_w = R_ORAM; head_eng = 2'd2; end
      default:   ;
    endcase
  end

  always_comb begin
    infl_r   = '0;
    infl_w   = '0;
    all_idle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (eng_st[i] == ENG_BUSY) begin
        infl_r   = infl_r | eng_r[i];
        infl_w   = infl_w | eng_w[i];
        all_idle = 1'b0;
      end
    end
  end

  assign hazard = (|(head_w & (infl_r | infl_w))) | (|(head_r & infl_w));

  // Engine FSMs: dispatch request and next state from registered state only.
  always_comb begin
    eng_vld = '0;
    for (int i = 0; i < 3; i++) begin
      eng_nxt[i] = eng_st[i];
      eng_vld[i] = ~empty & (head_eng == 2'(i)) & (eng_st[i] == ENG_IDLE) & ~hazard;
      case (eng_st[i])
        ENG_IDLE: if (eng_vld[i] & eng_rdy[i]) eng_nxt[i] = ENG_BUSY;
        ENG_BUSY: if (eng_done[i])             eng_nxt[i] = ENG_IDLE;
        default:                               eng_nxt[i] = ENG_IDLE;
      endcase
    end
  end

  assign eng_hs  = eng_vld & eng_rdy;
  assign wfi_pop = ~empty & (head_cmd == C_WFI) & all_idle;
  assign pop     = (|eng_hs) | wfi_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        eng_st[i] <= ENG_IDLE;
        eng_r[i]  <= '0;
        eng_w[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        eng_st[i] <= eng_nxt[i];
        if (eng_hs[i]) begin
          eng_r[i] <= head_r;
          eng_w[i] <= head_w;
        end else if (eng_st[i] == ENG_BUSY && eng_done[i]) begin
          eng_r[i] <= '0;
          eng_w[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= alu_sch_vld & ~full & ~alu_sch_flush & illegal;
      if (alu_sch_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      cmd_q[wr_ptr] <= alu_sch_cmd;
      pld_q[wr_ptr] <= alu_sch_pld;
    end
  end

  assign sch_alu_rdy  = ~full;
  assign sch_dma_vld  = eng_vld[0];
  assign sch_mm_vld   = eng_vld[1];
  assign sch_vec_vld  = eng_vld[2];
  assign sch_cmd      = head_cmd;
  assign sch_pld      = head_pld;
  assign sch_wfi_done = wfi_pop;
  assign sch_err      = err_q;
  assign sch_busy     = ~empty | ~all_idle;

endmodule

// File: tb/tb_npu_cmd_sched.sv
// Randomized and directed bench for npu_cmd_sched against a queue-based reference model.
module tb_npu_cmd_sched;
  localparam int DEPTH = 4;
  localparam int PLD_W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             alu_sch_vld;
  logic [3:0]       alu_sch_cmd;
  logic [PLD_W-1:0] alu_sch_pld;
  logic             sch_alu_rdy;
  logic             alu_sch_flush;
  logic             sch_dma_vld, sch_mm_vld, sch_vec_vld;
  logic             dma_sch_rdy, mm_sch_rdy, vec_sch_rdy;
  logic             dma_sch_done, mm_sch_done, vec_sch_done;
  logic [3:0]       sch_cmd;
  logic [PLD_W-1:0] sch_pld;
  logic             sch_wfi_done, sch_err, sch_busy;

  npu_cmd_sched #(.DEPTH(DEPTH), .PLD_W(PLD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_sch_vld(alu_sch_vld), .alu_sch_cmd(alu_sch_cmd), .alu_sch_pld(alu_sch_pld),
    .sch_alu_rdy(sch_alu_rdy), .alu_sch_flush(alu_sch_flush),
    .sch_dma_vld(sch_dma_vld), .sch_mm_vld(sch_mm_vld), .sch_vec_vld(sch_vec_vld),
    .dma_sch_rdy(dma_sch_rdy), .mm_sch_rdy(mm_sch_rdy), .vec_sch_rdy(vec_sch_rdy),
    .dma_sch_done(dma_sch_done), .mm_sch_done(mm_sch_done), .vec_sch_done(vec_sch_done),
    .sch_cmd(sch_cmd), .sch_pld(sch_pld), .sch_wfi_done(sch_wfi_done),
    .sch_err(sch_err), .sch_busy(sch_busy)
  );

  typedef struct packed {
    logic [3:0]  cmd;
    logic [63:0] pld;
  } ent_t;

  ent_t       q[$];
  bit         m_busy [3];
  logic [2:0] m_r [3];
  logic [2:0] m_w [3];
  bit         m_err;
  int         errors = 0;
  int         checks = 0;
  bit         chk_on = 0;

  // Read/write SRAM sets per command: bit0 iram, bit1 wram, bit2 oram.
  function automatic void res(input logic [3:0] c, output logic [2:0] r, output logic [2:0] w);
    r = 3'b000; w = 3'b000;
    case (c)
      4'd0: w = 3'b001;
      4'd1: w = 3'b010;
      4'd2: r = 3'b001;
      4'd3: r = 3'b010;
      4'd4: r = 3'b100;
      4'd5: begin r = 3'b011; w = 3'b100; end
      4'd6, 4'd7: begin r = 3'b100; w = 3'b100; end
      default: ;
    endcase
  endfunction

  function automatic int eng_of(input logic [3:0] c);
    if (c <= 4'd4) return 0;
    if (c == 4'd5) return 1;
    if (c == 4'd6 || c == 4'd7) return 2;
    return 3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare DUT against model, advance model, return 1 time unit after the edge.
  task automatic cyc();
    logic [2:0] ir, iw, hr, hw;
    bit         haz, has, ewfi, epush;
    bit [2:0]   ev, rdy_v, done_v;
    int         he;
    ent_t       h;
    @(negedge clk);
    rdy_v  = {vec_sch_rdy, mm_sch_rdy, dma_sch_rdy};
    done_v = {vec_sch_done, mm_sch_done, dma_sch_done};
    has = (q.size() > 0);
    h   = has ? q[0] : '0;
    ir = 3'b000; iw = 3'b000;
    for (int i = 0; i < 3; i++) if (m_busy[i]) begin ir |= m_r[i]; iw |= m_w[i]; end
    res(h.cmd, hr, hw);
    haz = ((hw & (ir | iw)) != 3'b000) || ((hr & iw) != 3'b000);
    he  = eng_of(h.cmd);
    for (int i = 0; i < 3; i++) ev[i] = has && (he == i) && !m_busy[i] && !haz;
    ewfi = has && (h.cmd == 4'd8) && !m_busy[0] && !m_busy[1] && !m_busy[2];
    if (chk_on) begin
      chk("alu_rdy", sch_alu_rdy, q.size() < DEPTH);
      chk("dma_vld", sch_dma_vld, ev[0]);
      chk("mm_vld",  sch_mm_vld,  ev[1]);
      chk("vec_vld", sch_vec_vld, ev[2]);
      chk("cmd",     sch_cmd,     h.cmd);
      chk("pld",     sch_pld,     h.pld);
      chk("wfi_done", sch_wfi_done, ewfi);
      chk("err",     sch_err,     m_err);
      chk("busy",    sch_busy,    has || m_busy[0] || m_busy[1] || m_busy[2]);
    end
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 3; i++) begin m_busy[i] = 0; m_r[i] = '0; m_w[i] = '0; end
      m_err = 0;
    end else begin
      epush = alu_sch_vld && (q.size() < DEPTH) && !alu_sch_flush && (alu_sch_cmd <= 4'd8);
      m_err = alu_sch_vld && (q.size() < DEPTH) && !alu_sch_flush && (alu_sch_cmd > 4'd8);
      for (int i = 0; i < 3; i++) begin
        if (ev[i] && rdy_v[i]) begin m_busy[i] = 1; m_r[i] = hr; m_w[i] = hw; end
        else if (m_busy[i] && done_v[i]) m_busy[i] = 0;
      end
      if ((ev & rdy_v) != 3'b000 || ewfi) void'(q.pop_front());
      if (alu_sch_flush) q.delete();
      else if (epush) q.push_back('{cmd: alu_sch_cmd, pld: alu_sch_pld});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [3:0] c, input logic [63:0] p);
    alu_sch_vld = 1'b1; alu_sch_cmd = c; alu_sch_pld = p;
  endtask

  task automatic drain();
    alu_sch_vld = 0; alu_sch_flush = 0;
    dma_sch_rdy = 1; mm_sch_rdy = 1; vec_sch_rdy = 1;
    dma_sch_done = 1; mm_sch_done = 1; vec_sch_done = 1;
    repeat (14) cyc();
    dma_sch_rdy = 0; mm_sch_rdy = 0; vec_sch_rdy = 0;
    dma_sch_done = 0; mm_sch_done = 0; vec_sch_done = 0;
    cyc();
    chk("drain_idle", sch_busy, 0);
  endtask

  initial begin
    rst_n = 0; alu_sch_vld = 0; alu_sch_cmd = 0; alu_sch_pld = 0; alu_sch_flush = 0;
    dma_sch_rdy = 0; mm_sch_rdy = 0; vec_sch_rdy = 0;
    dma_sch_done = 0; mm_sch_done = 0; vec_sch_done = 0;
    cyc(); cyc();
    rst_n = 1;
    chk_on = 1;
    chk("rst_rdy", sch_alu_rdy, 1);
    chk("rst_vld", {sch_dma_vld, sch_mm_vld, sch_vec_vld}, 0);
    chk("rst_busy", sch_busy, 0);
    chk("rst_cmd", sch_cmd, 0);
    chk("rst_pld", sch_pld, 0);
    chk("rst_err_wfi", {sch_err, sch_wfi_done}, 0);

    // LD_IRAM then CONV: CONV waits on iram RAW until the load completes.
    dma_sch_rdy = 1; mm_sch_rdy = 1;
    set_push(4'd0, 64'h11); cyc();
    chk("s1_ld_disp", sch_dma_vld, 1);
    set_push(4'd5, 64'h22); cyc();
    alu_sch_vld = 0;
    chk("s1_conv_held", sch_mm_vld, 0);
    cyc();
    chk("s1_conv_held2", sch_mm_vld, 0);
    dma_sch_done = 1; cyc(); dma_sch_done = 0;
    chk("s1_conv_go", sch_mm_vld, 1);
    chk("s1_conv_cmd", sch_cmd, 5);

    // ST_WRAM proceeds beside in-flight CONV; LD_WRAM then waits on WAR.
    set_push(4'd3, 64'h33); cyc();
    chk("s2_st_rr_ok", sch_dma_vld, 1);
    set_push(4'd1, 64'h44); cyc();
    alu_sch_vld = 0;
    dma_sch_done = 1; cyc(); dma_sch_done = 0;
    chk("s2_ldw_war", sch_dma_vld, 0);
    cyc();
    chk("s2_ldw_war2", sch_dma_vld, 0);
    mm_sch_done = 1; cyc(); mm_sch_done = 0;
    chk("s2_ldw_go", sch_dma_vld, 1);
    cyc();
    drain();

    // Full FIFO: fifth push ignored, rdy returns after one pop.
    for (int k = 0; k < 4; k++) begin set_push(4'd0, 64'(k + 100)); cyc(); end
    chk("s3_full", sch_alu_rdy, 0);
    set_push(4'd2, 64'h55); cyc();
    alu_sch_vld = 0;
    chk("s3_full_hold", sch_alu_rdy, 0);
    dma_sch_rdy = 1; cyc(); dma_sch_rdy = 0;
    chk("s3_rdy_back", sch_alu_rdy, 1);
    drain();

    // WFI waits for VEC to drain, then retires one cycle after done.
    vec_sch_rdy = 1;
    set_push(4'd6, 64'h66); cyc();
    set_push(4'd8, 64'h77); cyc();
    alu_sch_vld = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("s4_wfi_wait", sch_wfi_done, 0);
      chk("s4_busy", sch_busy, 1);
    end
    vec_sch_done = 1; cyc(); vec_sch_done = 0;
    chk("s4_wfi_pulse", sch_wfi_done, 1);
    cyc();
    chk("s4_wfi_once", sch_wfi_done, 0);
    chk("s4_busy_fall", sch_busy, 0);
    vec_sch_rdy = 0;

    // Illegal code.
    set_push(4'd12, 64'h88); cyc();
    alu_sch_vld = 0;
    chk("s5_err", sch_err, 1);
    chk("s5_busy", sch_busy, 0);
    chk("s5_rdy", sch_alu_rdy, 1);
    cyc();
    chk("s5_err_once", sch_err, 0);

    // Flush coincident with head dispatch.
    set_push(4'd4, 64'h91); cyc();
    set_push(4'd5, 64'h92); cyc();
    set_push(4'd6, 64'h93); cyc();
    chk("s6_head_vld", sch_dma_vld, 1);
    set_push(4'd0, 64'h94);
    dma_sch_rdy = 1; alu_sch_flush = 1; cyc();
    alu_sch_flush = 0; dma_sch_rdy = 0; alu_sch_vld = 0;
    chk("s6_busy", sch_busy, 1);
    chk("s6_empty_cmd", sch_cmd, 0);
    chk("s6_no_mm", sch_mm_vld, 0);
    repeat (3) cyc();
    chk("s6_busy_hold", sch_busy, 1);
    dma_sch_done = 1; cyc(); dma_sch_done = 0;
    chk("s6_busy_done", sch_busy, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      alu_sch_vld   = ($urandom_range(0, 2) != 0);
      alu_sch_cmd   = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      alu_sch_pld   = {$urandom, $urandom};
      alu_sch_flush = ($urandom_range(0, 39) == 0);
      dma_sch_rdy   = ($urandom_range(0, 3) != 0);
      mm_sch_rdy    = ($urandom_range(0, 3) != 0);
      vec_sch_rdy   = ($urandom_range(0, 3) != 0);
      dma_sch_done  = ($urandom_range(0, 3) == 0);
      mm_sch_done   = ($urandom_range(0, 4) == 0);
      vec_sch_done  = ($urandom_range(0, 3) == 0);
      cyc();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
